// File: rtl/int_div_pkg.sv
// Shared types and special-case helpers for the integer divide unit.
// Helpers work on a 64-bit container; callers zero-extend operands and truncate
// results to their own WIDTH (WIDTH must not exceed MaxWidth).
package int_div_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } div_state_e;

  localparam int unsigned MaxWidth = 64;
  typedef logic [MaxWidth-1:0] word_t;

  // Low w bits set.
  function automatic word_t all_ones(int unsigned w);
    if (w >= MaxWidth) return '1;
    return (word_t'(1) << w) - word_t'(1);
  endfunction

  // Signed most-negative / -1, the only signed quotient that overflows.
  function automatic logic is_overflow(word_t n, word_t d, int unsigned w);
    return (n == (word_t'(1) << (w - 1))) && (d == all_ones(w));
  endfunction

  // Quotient for a special case: all ones on divide-by-zero, else the dividend.
  function automatic word_t spec_quot(logic dbz, word_t n, int unsigned w);
    return dbz ? all_ones(w) : n;
  endfunction

  // Remainder for a special case: the dividend on divide-by-zero, else zero.
  function automatic word_t spec_rem(logic dbz, word_t n);
    return dbz ? n : '0;
  endfunction

endpackage

// File: rtl/int_div_step.sv
// One combinational restoring radix-2 division step on magnitudes.
module int_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             bit_i,
  output logic [WIDTH:0]   rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  // Partial remainder is always below the divisor, so its top bit never survives the shift.
  logic           unused_rem_msb;

  assign unused_rem_msb = rem_i[WIDTH];
  assign shifted        = {rem_i[WIDTH-1:0], bit_i};
  assign diff           = shifted - {1'b0, div_i};
  // Top bit of the difference is the sign: clear means the trial subtraction fits.
  assign qbit_o         = ~diff[WIDTH];
  assign rem_o          = qbit_o ? diff : shifted;

endmodule

// File: rtl/int_divrem.sv
// Multi-cycle radix-2 signed/unsigned integer divider with quotient and remainder.
// Optional build macro INT_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow
// complete one cycle after accept instead of running the full datapath.
module int_divrem
  import int_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o,
  output logic             dbz_o,
  output logic             valid_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] nraw_q, nraw_d; // original dividend, needed for special-case results
  logic             sq_q, sq_d, sr_q, sr_d;
  logic             dbz_case_q, dbz_case_d, ovf_case_q, ovf_case_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d;
  logic             dbz_q, dbz_d;

  logic             n_neg, d_neg, dbz_case, ovf_case;
  logic [WIDTH-1:0] n_abs, d_abs;
  logic [WIDTH:0]   step_rem;
  logic             step_qbit;

  assign n_neg    = signed_i & n_i[WIDTH-1];
  assign d_neg    = signed_i & d_i[WIDTH-1];
  assign n_abs    = n_neg ? -n_i : n_i;
  assign d_abs    = d_neg ? -d_i : d_i;
  assign dbz_case = (d_i == '0);
  assign ovf_case = signed_i & is_overflow(word_t'(n_i), word_t'(d_i), WIDTH);

  int_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .div_i (div_q),
    .bit_i (quo_q[WIDTH-1]),
    .rem_o (step_rem),
    .qbit_o(step_qbit)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    div_d      = div_q;
    nraw_d     = nraw_q;
    sq_d       = sq_q;
    sr_d       = sr_q;
    dbz_case_d = dbz_case_q;
    ovf_case_d = ovf_case_q;
    q_d        = q_q;
    r_d        = r_q;
    dbz_d      = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          sq_d       = n_neg ^ d_neg;
          sr_d       = n_neg;
          rem_d      = '0;
          quo_d      = n_abs;
          div_d      = d_abs;
          nraw_d     = n_i;
          dbz_case_d = dbz_case;
          ovf_case_d = ovf_case;
          cnt_d      = CntW'(WIDTH - 1);
          state_d    = StRun;
`ifdef INT_DIV_EARLY_OUT_EN
          if (dbz_case || ovf_case) begin
            q_d     = WIDTH'(spec_quot(dbz_case, word_t'(n_i), WIDTH));
            r_d     = WIDTH'(spec_rem(dbz_case, word_t'(n_i)));
            dbz_d   = dbz_case;
            state_d = StDone;
          end
`endif
        end
      end
      StRun: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_qbit};
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StFix: begin
        if (dbz_case_q || ovf_case_q) begin
          q_d   = WIDTH'(spec_quot(dbz_case_q, word_t'(nraw_q), WIDTH));
          r_d   = WIDTH'(spec_rem(dbz_case_q, word_t'(nraw_q)));
          dbz_d = dbz_case_q;
        end else begin
          q_d   = sq_q ? -quo_q : quo_q;
          r_d   = sr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          dbz_d = 1'b0;
        end
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      div_q      <= '0;
      nraw_q     <= '0;
      sq_q       <= 1'b0;
      sr_q       <= 1'b0;
      dbz_case_q <= 1'b0;
      ovf_case_q <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      div_q      <= div_d;
      nraw_q     <= nraw_d;
      sq_q       <= sq_d;
      sr_q       <= sr_d;
      dbz_case_q <= dbz_case_d;
      ovf_case_q <= ovf_case_d;
      q_q        <= q_d;
      r_q        <= r_d;
      dbz_q      <= dbz_d;
    end
  end

  assign ready_o = (state_q == StIdle);
  assign valid_o = (state_q == StDone);
  assign q_o     = q_q;
  assign r_o     = r_q;
  assign dbz_o   = dbz_q;

endmodule

// File: tb/tb_int_divrem.sv
// Self-checking bench for int_divrem (WIDTH=32): directed cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_int_divrem;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         start_i = 1'b0;
  logic         signed_i = 1'b0;
  logic [W-1:0] n_i = '0;
  logic [W-1:0] d_i = '0;
  logic         ready_o, dbz_o, valid_o;
  logic [W-1:0] q_o, r_o;

  int checks = 0;
  int errors = 0;

  int_divrem #(
    .WIDTH(W)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .start_i (start_i),
    .signed_i(signed_i),
    .n_i     (n_i),
    .d_i     (d_i),
    .ready_o (ready_o),
    .q_o     (q_o),
    .r_o     (r_o),
    .dbz_o   (dbz_o),
    .valid_o (valid_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M division semantics from plain integer arithmetic.
  task automatic model(input logic [W-1:0] n, input logic [W-1:0] d, input logic s,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dbz,
                       output logic special);
    longint ns, ds;
    dbz     = 1'b0;
    special = 1'b0;
    if (d == 0) begin
      q = '1; r = n; dbz = 1'b1; special = 1'b1;
    end else if (s && n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
      q = n; r = '0; special = 1'b1;
    end else if (s) begin
      ns = longint'($signed(n));
      ds = longint'($signed(d));
      q  = W'(ns / ds);
      r  = W'(ns % ds);
    end else begin
      q = n / d;
      r = n % d;
    end
  endtask

  // Issue one operation from a negedge with ready_o high; returns on the negedge after valid_o.
  // intr > 0 pulses a competing start_i in that cycle after accept.
  task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d, input logic s,
                        input int intr, input string tag);
    logic [W-1:0] eq, er;
    logic         edbz, spec;
    int           lat, exp_lat;
    logic         ready_bad;
    model(n, d, s, eq, er, edbz, spec);
`ifdef INT_DIV_EARLY_OUT_EN
    exp_lat = spec ? 1 : W + 2;
`else
    exp_lat = W + 2;
`endif
    chk({tag, ".ready_before"}, W'(ready_o), W'(1));
    start_i  = 1'b1;
    n_i      = n;
    d_i      = d;
    signed_i = s;
    @(negedge clk);
    start_i   = 1'b0;
    lat       = 1;
    ready_bad = 1'b0;
    while (valid_o !== 1'b1 && lat <= 100) begin
      if (ready_o !== 1'b0) ready_bad = 1'b1;
      if (lat == intr) begin
        start_i = 1'b1; n_i = 32'h0000_1234; d_i = 32'h7; signed_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start_i = 1'b0;
    if (ready_o !== 1'b0) ready_bad = 1'b1;
    chk({tag, ".latency"}, W'(lat), W'(exp_lat));
    chk({tag, ".ready_low"}, W'(ready_bad), W'(0));
    chk({tag, ".q"}, q_o, eq);
    chk({tag, ".r"}, r_o, er);
    chk({tag, ".dbz"}, W'(dbz_o), W'(edbz));
    @(negedge clk);
    chk({tag, ".valid_pulse"}, W'(valid_o), W'(0));
    chk({tag, ".ready_after"}, W'(ready_o), W'(1));
    chk({tag, ".q_hold"}, q_o, eq);
  endtask

  initial begin
    logic [W-1:0] rn, rd;
    logic         rs;
    logic         vseen;

    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset.ready", W'(ready_o), W'(1));
    chk("reset.valid", W'(valid_o), W'(0));
    chk("reset.q", q_o, '0);
    chk("reset.r", r_o, '0);
    chk("reset.dbz", W'(dbz_o), W'(0));
    reset_i = 1'b0;
    @(negedge clk);

    run_op(32'd100, 32'd7, 1'b0, 0, "u100_7");
    run_op(-32'sd7, 32'd2, 1'b1, 0, "s_m7_2");
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 0, "u_fff9_2");
    run_op(32'd5, 32'd0, 1'b0, 0, "u5_0");
    run_op(32'd5, 32'd0, 1'b1, 0, "s5_0");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "s_ovf");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "u_ovf_ops");
    // Competing start at T+5 must be dropped; the following op is accepted back-to-back.
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 5, "ignored_start");
    run_op(32'd77, 32'd10, 1'b0, 0, "b2b");
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, "pre_abort");

    // Abort an operation with reset_i at T+10.
    start_i = 1'b1; n_i = 32'd1000; d_i = 32'd3; signed_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    vseen = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (valid_o === 1'b1) vseen = 1'b1;
      @(negedge clk);
    end
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    chk("abort.no_valid_before", W'(vseen), W'(0));
    chk("abort.valid", W'(valid_o), W'(0));
    chk("abort.ready", W'(ready_o), W'(1));
    chk("abort.q", q_o, '0);
    chk("abort.r", r_o, '0);
    chk("abort.dbz", W'(dbz_o), W'(0));
    run_op(32'd9, 32'd3, 1'b0, 0, "after_abort");

    for (int k = 0; k < 24; k++) begin
      rn = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: rd = '0;
        1: rd = W'($urandom_range(1, 15));
        2: rd = '1;
        3: rd = -W'($urandom_range(1, 15));
        default: rd = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) rn = 32'h8000_0000;
      run_op(rn, rd, rs, 0, $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
